// File: rtl/wb_test_master.sv
// wb_test_master: Wishbone classic initiator for DV benches.
//   A start pulse begins a run. The run writes NUM_WORDS patterned words
//   (data_k = SEED + k*32'h0101_0101) at BASE_ADR + 4*k. It then reads every
//   word back and compares each one against the pattern. At the end it reports
//   pass/fail, the mismatch count, the first failing address and any ack timeout.
// Ports:
//   wb_clk_i, wb_rst_i (sync, active-high), start_i
//   wb_cyc_o/wb_stb_o/wb_we_o/wb_sel_o/wb_adr_o/wb_dat_o, wb_dat_i, wb_ack_i
//   busy_o, done_o, pass_o, timeout_o, err_cnt_o, fail_adr_o
module wb_test_master #(
    parameter logic [31:0] BASE_ADR  = 32'h3000_0000,
    parameter int          NUM_WORDS = 8,
    parameter logic [31:0] SEED      = 32'hA5A5_0001,
    parameter int          TIMEOUT   = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        timeout_o,
    output logic [7:0]  err_cnt_o,
    output logic [31:0] fail_adr_o
);
    localparam int          KW   = $clog2(NUM_WORDS + 1);
    localparam logic [31:0] STEP = 32'h0101_0101;
    localparam logic [KW-1:0] LAST = KW'(NUM_WORDS - 1);
    localparam logic [15:0] TLIM = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE} state_t;

    state_t        state_q;
    logic [KW-1:0] k_q;
    logic [15:0]   tcnt_q;
    logic          cyc_q, stb_q, we_q;
    logic [3:0]    sel_q;
    logic [31:0]   adr_q, dat_q;
    logic          busy_q, done_q, pass_q, to_q;
    logic [7:0]    err_q;
    logic [31:0]   fail_q;

    function automatic logic [31:0] adr_of(input logic [KW-1:0] k);
        return BASE_ADR + (32'(k) << 2);
    endfunction

    function automatic logic [31:0] pat_of(input logic [KW-1:0] k);
        return SEED + STEP * 32'(k);
    endfunction

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            tcnt_q  <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            adr_q   <= '0;
            dat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            to_q    <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        to_q    <= 1'b0;
                        err_q   <= '0;
                        fail_q  <= '0;
                        busy_q  <= 1'b1;
                        k_q     <= '0;
                        tcnt_q  <= '0;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= 1'b1;
                        sel_q   <= 4'hF;
                        adr_q   <= adr_of('0);
                        dat_q   <= pat_of('0);
                        state_q <= WR_REQ;
                    end
                end
                WR_REQ, RD_REQ: begin
                    // Only REQ states look at ack, so acks while stb is low are ignored.
                    if (wb_ack_i) begin
                        cyc_q <= 1'b0;
                        stb_q <= 1'b0;
                        we_q  <= 1'b0;
                        sel_q <= 4'h0;
                        adr_q <= '0;
                        dat_q <= '0;
                        if (state_q == RD_REQ) begin
                            if (wb_dat_i != pat_of(k_q)) begin
                                if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                                // Keep only the first failing address.
                                if (err_q == 8'h00) fail_q <= adr_q;
                            end
                            state_q <= RD_GAP;
                        end else begin
                            state_q <= WR_GAP;
                        end
                    end else if (tcnt_q == TLIM) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        sel_q   <= 4'h0;
                        adr_q   <= '0;
                        dat_q   <= '0;
                        to_q    <= 1'b1;
                        pass_q  <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        tcnt_q <= tcnt_q + 16'd1;
                    end
                end
                WR_GAP: begin
                    // After the last write, start the read phase at word 0.
                    tcnt_q <= '0;
                    cyc_q  <= 1'b1;
                    stb_q  <= 1'b1;
                    sel_q  <= 4'hF;
                    if (k_q == LAST) begin
                        k_q     <= '0;
                        we_q    <= 1'b0;
                        adr_q   <= adr_of('0);
                        dat_q   <= '0;
                        state_q <= RD_REQ;
                    end else begin
                        k_q     <= k_q + 1'b1;
                        we_q    <= 1'b1;
                        adr_q   <= adr_of(k_q + 1'b1);
                        dat_q   <= pat_of(k_q + 1'b1);
                        state_q <= WR_REQ;
                    end
                end
                RD_GAP: begin
                    if (k_q == LAST) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        pass_q  <= (err_q == 8'h00);
                        state_q <= DONE;
                    end else begin
                        k_q     <= k_q + 1'b1;
                        tcnt_q  <= '0;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        sel_q   <= 4'hF;
                        adr_q   <= adr_of(k_q + 1'b1);
                        state_q <= RD_REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = stb_q;
    assign wb_we_o    = we_q;
    assign wb_sel_o   = sel_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign pass_o     = pass_q;
    assign timeout_o  = to_q;
    assign err_cnt_o  = err_q;
    assign fail_adr_o = fail_q;
endmodule

// File: tb/tb_wb_test_master.sv
// Bench for wb_test_master. Instance 0 uses the default parameters and a memory
// slave that has a programmable wait count and corrupts selected words on read.
// Instance 1 has NUM_WORDS=4 and TIMEOUT=10. Its slave is either a single
// aliased register or a slave that never acks.
module tb_wb_test_master;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] SEED = 32'hA5A5_0001;
    localparam logic [31:0] STEP = 32'h0101_0101;
    localparam int MEM = 0, REG = 1, NOACK = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i [2];
    logic        cyc [2], stb [2], we [2], ack [2], ack_q [2], stray [2];
    logic [3:0]  sel [2];
    logic [31:0] adr [2], dato [2], dati [2];
    logic        busy [2], done [2], pass [2], tmo [2];
    logic [7:0]  err [2];
    logic [31:0] fail [2];

    int          mode [2];
    int          waits [2];
    int          wcnt [2];
    logic [7:0]  corrupt [2];
    logic [31:0] mem [2][256];
    logic [31:0] sreg [2];

    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    wb_test_master dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_i[0]),
        .wb_cyc_o(cyc[0]), .wb_stb_o(stb[0]), .wb_we_o(we[0]), .wb_sel_o(sel[0]),
        .wb_adr_o(adr[0]), .wb_dat_o(dato[0]), .wb_dat_i(dati[0]), .wb_ack_i(ack[0]),
        .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]), .timeout_o(tmo[0]),
        .err_cnt_o(err[0]), .fail_adr_o(fail[0])
    );

    wb_test_master #(.NUM_WORDS(4), .TIMEOUT(10)) dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_i[1]),
        .wb_cyc_o(cyc[1]), .wb_stb_o(stb[1]), .wb_we_o(we[1]), .wb_sel_o(sel[1]),
        .wb_adr_o(adr[1]), .wb_dat_o(dato[1]), .wb_dat_i(dati[1]), .wb_ack_i(ack[1]),
        .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]), .timeout_o(tmo[1]),
        .err_cnt_o(err[1]), .fail_adr_o(fail[1])
    );

    always_comb begin
        for (int i = 0; i < 2; i++) ack[i] = ack_q[i] | stray[i];
    end

    // Slaves: ack is registered and arrives after waits[i] extra stb cycles.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                ack_q[i] <= 1'b0;
                wcnt[i]  <= 0;
            end else if (cyc[i] && stb[i] && !ack_q[i] && mode[i] != NOACK) begin
                if (wcnt[i] == waits[i]) begin
                    ack_q[i] <= 1'b1;
                    wcnt[i]  <= 0;
                    if (mode[i] == MEM) begin
                        if (we[i]) mem[i][adr[i][9:2]] <= dato[i];
                        else dati[i] <= mem[i][adr[i][9:2]] ^ {31'd0, corrupt[i][adr[i][4:2]]};
                    end else begin
                        if (we[i]) sreg[i] <= dato[i];
                        else dati[i] <= sreg[i];
                    end
                end else begin
                    wcnt[i] <= wcnt[i] + 1;
                end
            end else begin
                ack_q[i] <= 1'b0;
                if (!stb[i]) wcnt[i] <= 0;
            end
        end
    end

    // Monitor for instance 0: logs transactions and stb lengths, and flags
    // bus signals that change while stb is held or a bad sel value.
    logic [64:0] txq [$];
    int          lenq [$];
    int          run_len = 0, unstable = 0, sel_bad = 0;
    logic        p_stb = 1'b0;
    logic [68:0] p_bus = '0;
    always @(negedge clk) begin
        if (stb[0] && ack[0]) txq.push_back({we[0], adr[0], dato[0]});
        if (stb[0] && sel[0] != 4'hF) sel_bad++;
        if (!stb[0] && sel[0] != 4'h0) sel_bad++;
        if (stb[0] && p_stb && {we[0], sel[0], adr[0], dato[0]} != p_bus) unstable++;
        if (stb[0]) run_len++;
        else if (p_stb) begin
            lenq.push_back(run_len);
            run_len = 0;
        end
        p_stb = stb[0];
        p_bus = {we[0], sel[0], adr[0], dato[0]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pulse start, then count edges until done (bounded).
    task automatic do_run(input int i, output int n);
        @(negedge clk);
        start_i[i] = 1'b1;
        @(posedge clk);
        #1 start_i[i] = 1'b0;
        n = 0;
        while (!done[i] && n < 3000) begin
            @(posedge clk);
            #1 n++;
        end
        chk("run_done", {31'd0, done[i]}, 32'd1);
    endtask

    // Reference transaction list: NUM_WORDS writes of the pattern, then the reads.
    task automatic check_tx(input int base, input int exp_len);
        logic [64:0] e;
        chk("tx_count", txq.size() - base, 16);
        for (int j = 0; j < 16 && base + j < txq.size(); j++) begin
            if (j < 8) e = {1'b1, BASE + 32'(4 * j), SEED + STEP * 32'(j)};
            else       e = {1'b0, BASE + 32'(4 * (j - 8)), 32'd0};
            checks++;
            if (txq[base + j] !== e) begin
                errors++;
                $display("FAIL tx[%0d]: got %h, expected %h", j, txq[base + j], e);
            end
        end
        for (int j = 0; j < 16 && base + j < lenq.size(); j++)
            chk("stb_len", lenq[base + j], exp_len);
    endtask

    typedef struct {
        int          waits;
        logic [7:0]  mask;
        int          exp_err;
        logic [31:0] exp_fail;
        logic        exp_pass;
        int          exp_cyc;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int n, tb, lb;
        waits[0]   = v.waits;
        corrupt[0] = v.mask;
        tb = txq.size();
        lb = lenq.size();
        do_run(0, n);
        chk({tag, "_cycles"}, n, v.exp_cyc);
        chk({tag, "_err"}, {24'd0, err[0]}, v.exp_err);
        chk({tag, "_fail"}, fail[0], v.exp_fail);
        chk({tag, "_pass"}, {31'd0, pass[0]}, {31'd0, v.exp_pass});
        chk({tag, "_tmo"}, {31'd0, tmo[0]}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy[0]}, 32'd0);
        if (lb + 16 <= lenq.size()) check_tx(tb, v.waits + 2);
        else check_tx(tb, v.waits + 2);
    endtask

    initial begin
        vec_t tbl [4];
        vec_t v;
        int   n, nrd, len;
        logic ps;

        tbl[0] = '{0, 8'h00, 0, 32'h0,           1'b1, 48};
        tbl[1] = '{1, 8'h81, 2, 32'h3000_0000,   1'b0, 64};
        tbl[2] = '{2, 8'h10, 1, 32'h3000_0010,   1'b0, 80};
        tbl[3] = '{4, 8'h00, 0, 32'h0,           1'b1, 112};  // stb held 6 cycles

        for (int i = 0; i < 2; i++) begin
            start_i[i] = 1'b0; stray[i] = 1'b0; waits[i] = 0; corrupt[i] = '0;
            dati[i] = '0; sreg[i] = '0;
        end
        mode[0] = MEM;
        mode[1] = REG;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc_stb_we", {29'd0, cyc[0], stb[0], we[0]}, 32'd0);
        chk("rst_sel", {28'd0, sel[0]}, 32'd0);
        chk("rst_adr", adr[0], 32'd0);
        chk("rst_dat", dato[0], 32'd0);
        chk("rst_status", {28'd0, busy[0], done[0], pass[0], tmo[0]}, 32'd0);
        chk("rst_err", {24'd0, err[0]}, 32'd0);
        chk("rst_fail", fail[0], 32'd0);
        @(negedge clk) rst = 1'b0;

        // Deterministic vectors.
        foreach (tbl[t]) run_vec(tbl[t], $sformatf("vec%0d", t));

        // Randomized runs against the reference model.
        for (int r = 0; r < 6; r++) begin
            v.waits = $urandom_range(0, 3);
            v.mask  = (r % 3 == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            v.exp_err = 0;
            v.exp_fail = 32'h0;
            for (int w = 7; w >= 0; w--)
                if (v.mask[w]) begin
                    v.exp_err++;
                    v.exp_fail = BASE + 32'(4 * w);
                end
            v.exp_pass = (v.exp_err == 0);
            v.exp_cyc  = 16 * (3 + v.waits);
            run_vec(v, $sformatf("rnd%0d", r));
        end

        // Start while busy and a stray ack in a gap cycle leave the run unchanged.
        waits[0] = 0;
        corrupt[0] = '0;
        fork
            do_run(0, n);
            begin
                repeat (10) @(negedge clk);
                start_i[0] = 1'b1;
                @(posedge clk);
                #1 start_i[0] = 1'b0;
                for (int g = 0; g < 40; g++) begin
                    @(negedge clk);
                    if (!stb[0] && busy[0]) break;
                end
                stray[0] = 1'b1;
                @(posedge clk);
                #1 stray[0] = 1'b0;
            end
        join
        chk("s6_cycles", n, 48);
        chk("s6_err", {24'd0, err[0]}, 32'd0);
        chk("s6_pass", {31'd0, pass[0]}, 32'd1);
        chk("s6_fail", fail[0], 32'd0);

        // Reset during the third read strobe.
        @(negedge clk);
        start_i[0] = 1'b1;
        @(posedge clk);
        #1 start_i[0] = 1'b0;
        nrd = 0;
        ps = 1'b0;
        for (int g = 0; g < 500 && nrd < 3; g++) begin
            @(negedge clk);
            if (stb[0] && !we[0] && !ps) nrd++;
            ps = stb[0];
        end
        chk("s5_reached_rd3", nrd, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("s5_cyc_stb", {30'd0, cyc[0], stb[0]}, 32'd0);
        chk("s5_status", {28'd0, busy[0], done[0], pass[0], tmo[0]}, 32'd0);
        chk("s5_err_fail", {24'd0, err[0]} | fail[0], 32'd0);
        @(negedge clk) rst = 1'b0;
        do_run(0, n);
        chk("s5_rerun_cycles", n, 48);
        chk("s5_rerun_pass", {31'd0, pass[0]}, 32'd1);

        // Single aliased register, 4 words: every read returns data_3.
        mode[1] = REG;
        do_run(1, n);
        chk("s2_cycles", n, 24);
        chk("s2_err", {24'd0, err[1]}, 32'd3);
        chk("s2_fail", fail[1], 32'h3000_0000);
        chk("s2_pass", {31'd0, pass[1]}, 32'd0);
        chk("s2_tmo", {31'd0, tmo[1]}, 32'd0);

        // Slave that never acks: timeout after 10 strobe cycles.
        mode[1] = NOACK;
        @(negedge clk);
        start_i[1] = 1'b1;
        @(posedge clk);
        #1 start_i[1] = 1'b0;
        len = 0;
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (!stb[1]) break;
            len++;
        end
        chk("s4_stb_len", len, 10);
        chk("s4_cyc", {31'd0, cyc[1]}, 32'd0);
        chk("s4_timeout", {31'd0, tmo[1]}, 32'd1);
        chk("s4_done", {31'd0, done[1]}, 32'd1);
        chk("s4_pass", {31'd0, pass[1]}, 32'd0);
        chk("s4_busy", {31'd0, busy[1]}, 32'd0);

        chk("bus_unstable", unstable, 0);
        chk("sel_bad", sel_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
